// File: rtl/traffic_request_conditioner_if.sv
// Request/acknowledge bundle between the board pushbuttons, the request
// conditioner and the traffic light controller.
interface traffic_request_conditioner_if;
   logic       walk_NS_key;
   logic       walk_EW_key;
   logic       left_turn_key;
   logic       ack_walk_NS;
   logic       ack_walk_EW;
   logic       ack_left_turn;
   logic       walk_request_NS;
   logic       walk_request_EW;
   logic       left_turn_request;
   logic [2:0] press_pulse;

   // Drives keys and acks; observes the conditioned requests.
   modport master (
      output walk_NS_key, walk_EW_key, left_turn_key,
      output ack_walk_NS, ack_walk_EW, ack_left_turn,
      input  walk_request_NS, walk_request_EW, left_turn_request, press_pulse
   );

   // The conditioner itself.
   modport slave (
      input  walk_NS_key, walk_EW_key, left_turn_key,
      input  ack_walk_NS, ack_walk_EW, ack_left_turn,
      output walk_request_NS, walk_request_EW, left_turn_request, press_pulse
   );
endinterface

// File: rtl/traffic_request_conditioner.sv
// Synchronises, debounces and press-edge detects three active-low buttons,
// then holds each press as a pending request until the controller acks it.
// Channel index: 2 = walk NS, 1 = walk EW, 0 = left turn.
module traffic_request_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned DEBOUNCE_DEBUG  = 4,
   parameter int unsigned CNT_W           = 19
) (
   input  logic                         clk_27,
   input  logic                         reset,
   input  logic                         debug,
   traffic_request_conditioner_if.slave bus
);

   localparam logic [CNT_W-1:0] LimNormM1  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LimDebugM1 = CNT_W'(DEBOUNCE_DEBUG - 1);

   logic [2:0]       key_raw;
   logic [2:0]       ack;
   logic [2:0]       s1_q, s2_q;
   logic [2:0]       db_q, db_d;
   logic [2:0]       db_dly_q;
   logic [2:0]       fall;
   logic [2:0]       pulse_q, pulse_d;
   logic [2:0]       req_q, req_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [CNT_W-1:0] lim_m1;

   assign key_raw = {bus.walk_NS_key, bus.walk_EW_key, bus.left_turn_key};
   assign ack     = {bus.ack_walk_NS, bus.ack_walk_EW, bus.ack_left_turn};

   // A change of debug mid-count takes effect immediately; the >= compare
   // lets a counter already beyond the new limit commit on the next edge.
   assign lim_m1 = debug ? LimDebugM1 : LimNormM1;

   // Debounce: commit s2 into db once it has differed for L consecutive samples.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] >= lim_m1) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Press = debounced 1->0; a same-cycle press beats the ack so no press is lost.
   always_comb begin
      fall    = db_dly_q & ~db_q;
      pulse_d = fall;
      req_d   = fall | (req_q & ~ack);
   end

   // Synchroniser, debounce state and press delay line.
   always_ff @(posedge clk_27 or negedge reset) begin
      if (!reset) begin
         s1_q     <= 3'b111;
         s2_q     <= 3'b111;
         db_q     <= 3'b111;
         db_dly_q <= 3'b111;
      end else begin
         s1_q     <= key_raw;
         s2_q     <= s1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
      end
   end

   // Per-channel debounce counters.
   always_ff @(posedge clk_27 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Registered press strobes and pending request levels.
   always_ff @(posedge clk_27 or negedge reset) begin
      if (!reset) begin
         pulse_q <= 3'b000;
         req_q   <= 3'b000;
      end else begin
         pulse_q <= pulse_d;
         req_q   <= req_d;
      end
   end

   assign bus.walk_request_NS   = req_q[2];
   assign bus.walk_request_EW   = req_q[1];
   assign bus.left_turn_request = req_q[0];
   assign bus.press_pulse       = pulse_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner. Observed word packs
// {req_NS, req_EW, req_left, press_pulse[2:0]}.
module tb_traffic_request_conditioner;

   logic clk_27 = 1'b0;
   logic reset  = 1'b0;
   logic debug  = 1'b1;
   int   n_vec  = 0;
   int   n_err  = 0;

   traffic_request_conditioner_if bus ();

   traffic_request_conditioner #(
      .DEBOUNCE_CYCLES (270000),
      .DEBOUNCE_DEBUG  (4),
      .CNT_W           (19)
   ) dut (
      .clk_27 (clk_27),
      .reset  (reset),
      .debug  (debug),
      .bus    (bus)
   );

   always #5 clk_27 = ~clk_27;

   logic [5:0] obs;
   assign obs = {bus.walk_request_NS, bus.walk_request_EW, bus.left_turn_request,
                 bus.press_pulse};

   // Advance one rising edge and settle; outputs then reflect that edge.
   task automatic tick();
      @(posedge clk_27);
      #1;
   endtask

   task automatic idle_inputs();
      bus.walk_NS_key   = 1'b1;
      bus.walk_EW_key   = 1'b1;
      bus.left_turn_key = 1'b1;
      bus.ack_walk_NS   = 1'b0;
      bus.ack_walk_EW   = 1'b0;
      bus.ack_left_turn = 1'b0;
   endtask

   task automatic fresh_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [5:0] exp;
      debug             = 1'b1;
      reset             = 1'b0;
      bus.walk_NS_key   = 1'b0;
      bus.walk_EW_key   = 1'b0;
      bus.left_turn_key = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_vec++;
         if (obs !== 6'b000_000) begin
            n_err++;
            $display("FAIL reset_hold cyc %0d: got %b want 000000", e, obs);
         end
      end
      reset = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp = (e == 7) ? 6'b111_111 : (e > 7) ? 6'b111_000 : 6'b000_000;
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_release edge %0d: got %b want %b", e, obs, exp);
         end
      end
   endtask

   task automatic test_press_ns();
      logic [5:0] exp;
      fresh_reset();
      bus.walk_NS_key = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp = (e == 7) ? 6'b100_100 : (e > 7) ? 6'b100_000 : 6'b000_000;
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL ns_press edge %0d: got %b want %b", e, obs, exp);
         end
      end
      bus.walk_NS_key = 1'b1;
      for (int e = 0; e < 10; e++) tick();
      n_vec++;
      if (obs !== 6'b100_000) begin
         n_err++;
         $display("FAIL ns_release_no_pulse: got %b want 100000", obs);
      end
   endtask

   // Relies on the NS request left pending by test_press_ns.
   task automatic test_ack();
      logic [5:0] exp;
      bus.ack_walk_NS = 1'b1;
      tick();
      bus.ack_walk_NS = 1'b0;
      n_vec++;
      if (obs !== 6'b000_000) begin
         n_err++;
         $display("FAIL ns_ack_clear: got %b want 000000", obs);
      end
      bus.ack_walk_NS = 1'b1;
      tick();
      tick();
      bus.ack_walk_NS = 1'b0;
      n_vec++;
      if (obs !== 6'b000_000) begin
         n_err++;
         $display("FAIL ns_ack_idle: got %b want 000000", obs);
      end
      bus.walk_NS_key = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         bus.ack_walk_NS = (e == 7);
         tick();
         exp = (e == 7) ? 6'b100_100 : (e > 7) ? 6'b100_000 : 6'b000_000;
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL ns_press_with_ack edge %0d: got %b want %b", e, obs, exp);
         end
      end
      bus.ack_walk_NS = 1'b0;
      bus.walk_NS_key = 1'b1;
   endtask

   task automatic test_glitch();
      fresh_reset();
      for (int e = 1; e <= 24; e++) begin
         bus.left_turn_key = !((e <= 3) || (e >= 7 && e <= 9));
         tick();
         n_vec++;
         if (obs !== 6'b000_000) begin
            n_err++;
            $display("FAIL left_glitch edge %0d: got %b want 000000", e, obs);
         end
      end
   endtask

   task automatic test_hold_ack();
      logic [5:0] exp;
      fresh_reset();
      bus.walk_EW_key = 1'b0;
      for (int e = 1; e <= 100; e++) begin
         bus.ack_walk_EW = (e == 21);
         tick();
         exp = (e == 7) ? 6'b010_010 : (e > 7 && e < 21) ? 6'b010_000 : 6'b000_000;
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL ew_hold edge %0d: got %b want %b", e, obs, exp);
         end
      end
      bus.ack_walk_EW = 1'b0;
      bus.walk_EW_key = 1'b1;
      for (int e = 0; e < 10; e++) tick();
      bus.walk_EW_key = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp = (e == 7) ? 6'b010_010 : (e > 7) ? 6'b010_000 : 6'b000_000;
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL ew_repress edge %0d: got %b want %b", e, obs, exp);
         end
      end
      bus.walk_EW_key = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp;
      fresh_reset();
      bus.walk_NS_key = 1'b0;
      for (int e = 1; e <= 4; e++) tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if (obs !== 6'b000_000) begin
         n_err++;
         $display("FAIL mid_reset_assert: got %b want 000000", obs);
      end
      tick();
      tick();
      reset = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp = (e == 7) ? 6'b100_100 : (e > 7) ? 6'b100_000 : 6'b000_000;
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_reset_release edge %0d: got %b want %b", e, obs, exp);
         end
      end
      bus.walk_NS_key = 1'b1;
   endtask

   task automatic test_normal_mode();
      debug = 1'b0;
      fresh_reset();
      bus.walk_NS_key = 1'b0;
      for (int e = 1; e <= 1000; e++) begin
         tick();
         if (e % 100 == 0) begin
            n_vec++;
            if (obs !== 6'b000_000) begin
               n_err++;
               $display("FAIL normal_long_limit edge %0d: got %b want 000000", e, obs);
            end
         end
      end
      // Switching to the short limit mid-count commits on the next edge.
      debug = 1'b1;
      tick();
      tick();
      n_vec++;
      if (obs !== 6'b100_100) begin
         n_err++;
         $display("FAIL debug_switch_commit: got %b want 100100", obs);
      end
      bus.walk_NS_key = 1'b1;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_press_ns();
      test_ack();
      test_glitch();
      test_hold_ack();
      test_reset_mid();
      test_normal_mode();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
